serial_adder: RTL

//   Bit-serial WIDTH-bit adder with one full-adder cell plus a carry flop, iterated LSB-first over WIDTH cycles.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_fac.sv | 13 +
 rtl/serial_adder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_fac.sv
// Single full-adder cell used by the bit-serial adder.
module fac (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_co
);

   assign o_s  = i_a ^ i_b ^ i_c;
   assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fac cell plus a carry flop, LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port for two's-complement subtraction.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             r_state;
   state_t             w_nextState;
   logic [WIDTH-1:0]   r_aSr;
   logic [WIDTH-1:0]   r_bSr;
   logic [WIDTH-1:0]   r_sumSr;
   logic               r_carry;
   logic [CNT_W-1:0]   r_count;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carryOut;

   logic               w_accept;
   logic               w_last;
   logic               w_subSel;
   logic [WIDTH-1:0]   w_bLoad;
   logic               w_carryLoad;
   logic               w_s;
   logic               w_co;

`ifdef SERIAL_ADDER_SUB_EN
   assign w_subSel = sub;
`else
   assign w_subSel = 1'b0;
`endif

   // Subtraction is a + ~b + 1, so the seed carry replaces carry_in.
   assign w_bLoad     = w_subSel ? ~b : b;
   assign w_carryLoad = w_subSel ? 1'b1 : carry_in;

   assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_last   = (r_state == ST_SHIFT) && (r_count == CNT_W'(WIDTH - 1));

   fac uFac (
      .i_a  (r_aSr[0]),
      .i_b  (r_bSr[0]),
      .i_c  (r_carry),
      .o_s  (w_s),
      .o_co (w_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_nextState = ST_SHIFT;
         ST_SHIFT: if (w_last) w_nextState = ST_DONE;
         ST_DONE:  w_nextState = start ? ST_SHIFT : ST_IDLE;
         default:  w_nextState = ST_IDLE;
      endcase
   end

   // Result registers only change on the final shift edge, so they hold across a new operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aSr      <= '0;
         r_bSr      <= '0;
         r_sumSr    <= '0;
         r_carry    <= 1'b0;
         r_count    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sum      <= '0;
         r_carryOut <= 1'b0;
      end else if (w_accept) begin
         r_aSr   <= a;
         r_bSr   <= w_bLoad;
         r_carry <= w_carryLoad;
         r_count <= '0;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
      end else if (r_state == ST_SHIFT) begin
         r_aSr   <= {1'b0, r_aSr[WIDTH-1:1]};
         r_bSr   <= {1'b0, r_bSr[WIDTH-1:1]};
         r_sumSr <= {w_s, r_sumSr[WIDTH-1:1]};
         r_carry <= w_co;
         if (w_last) begin
            r_sum      <= {w_s, r_sumSr[WIDTH-1:1]};
            r_carryOut <= w_co;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
         end else begin
            r_count <= r_count + CNT_W'(1);
         end
      end else begin
         r_done <= 1'b0;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign sum       = r_sum;
   assign carry_out = r_carryOut;

endmodule
